// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC rotation sequencer: Q-format widths,
// CORDIC core latency, vertex packing helper and sequencer FSM states.
package cordic_pkg;

  localparam int CORDIC_LAT = 14;

  // Fixed-point formats: inputs Q2.10, angle Q3.10, outputs Q2.8
  localparam int FRAC_IN  = 10;
  localparam int FRAC_OUT = 8;
  localparam int IN_W     = 2 + FRAC_IN;
  localparam int ANG_W    = 3 + FRAC_IN;
  localparam int OUT_W    = 2 + FRAC_OUT;
  localparam int PT_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } seq_state_e;

  // 6-bit unsigned vertex coordinate -> Q2.10 (value p/64)
  function automatic logic [IN_W-1:0] pack_coord(input logic [PT_W-1:0] p);
    return {{(IN_W-FRAC_IN){1'b0}}, p, {(FRAC_IN-PT_W){1'b0}}};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Simultaneous push and pop are
// accepted at any fill level; pop on empty and push on full (without a
// concurrent pop) are ignored.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);

  // Next pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = ptr_next(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = ptr_next(rd_ptr_q);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/cordic_rotate_sequencer.sv
// Streams a batch of ROM vertices through a fixed-latency CORDIC rotation
// core at one angle, tracks in-flight samples with a valid/index delay line
// and buffers results in an output FIFO. Issue is gated by credit so the
// FIFO can never overflow even though the core cannot stall.
module cordic_rotate_sequencer
  import cordic_pkg::*;
#(
  parameter int NPTS       = 16,
  parameter int IDX_W      = 4,
  parameter int CORDIC_LAT = cordic_pkg::CORDIC_LAT,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ANG_W-1:0]  theta,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  pt_idx,
  input  logic [PT_W-1:0]   pt_x,
  input  logic [PT_W-1:0]   pt_y,
  output logic              core_rst,
  output logic [IN_W-1:0]   cx,
  output logic [IN_W-1:0]   cy,
  output logic [ANG_W-1:0]  ca,
  input  logic [OUT_W-1:0]  cxo,
  input  logic [OUT_W-1:0]  cyo,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [OUT_W-1:0]  out_x,
  output logic [OUT_W-1:0]  out_y
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int FW    = IDX_W + 2 * OUT_W;
  localparam logic [CNT_W:0] OCC_MAX = (CNT_W+1)'(FIFO_DEPTH);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] pt_idx_q, pt_idx_d;
  logic [ANG_W-1:0] ca_q, ca_d;
  logic             issue;
  logic             done_c;

  logic             rd_vld_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [IN_W-1:0]  cx_q, cy_q;
  logic             cv_q;
  logic [IDX_W-1:0] ci_q;
  logic [CORDIC_LAT-1:0] dl_vld_q;
  logic [IDX_W-1:0] dl_idx_q [CORDIC_LAT];

  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;
  logic             has_credit;
  logic             fifo_empty;
  logic [FW-1:0]    fifo_rdata;
  logic             push, pop;

  // Credit uses pre-edge counts only: a pop this cycle frees space next cycle
  assign occupancy  = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign has_credit = (occupancy < OCC_MAX);
  assign push       = dl_vld_q[CORDIC_LAT-1];
  assign pop        = out_valid && out_ready;

  // Next-state, issue and done decode
  always_comb begin
    state_d  = state_q;
    pt_idx_d = pt_idx_q;
    ca_d     = ca_q;
    issue    = 1'b0;
    done_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_ISSUE;
          pt_idx_d = '0;
          ca_d     = theta;
        end
      end
      ST_ISSUE: begin
        if (has_credit) begin
          issue    = 1'b1;
          pt_idx_d = pt_idx_q + 1'b1;
          if (pt_idx_q == IDX_W'(NPTS - 1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((inflight_q == '0) && fifo_empty) begin
          state_d = ST_IDLE;
          done_c  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, ROM address and latched angle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pt_idx_q <= '0;
      ca_q     <= '0;
    end else begin
      state_q  <= state_d;
      pt_idx_q <= pt_idx_d;
      ca_q     <= ca_d;
    end
  end

  // ROM read tag, core input registers and delay-line valids
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      cv_q     <= 1'b0;
      ci_q     <= '0;
      dl_vld_q <= '0;
    end else begin
      rd_vld_q <= issue;
      rd_idx_q <= pt_idx_q;
      if (rd_vld_q) begin
        cx_q <= pack_coord(pt_x);
        cy_q <= pack_coord(pt_y);
      end
      cv_q     <= rd_vld_q;
      ci_q     <= rd_idx_q;
      dl_vld_q <= {dl_vld_q[CORDIC_LAT-2:0], cv_q};
    end
  end

  // Delay-line indices travel beside the valids; no reset needed
  always_ff @(posedge clk) begin
    dl_idx_q[0] <= ci_q;
    for (int unsigned i = 1; i < CORDIC_LAT; i++) begin
      dl_idx_q[i] <= dl_idx_q[i-1];
    end
  end

  // Count of samples issued but not yet pushed into the FIFO
  always_comb begin
    case ({issue, push})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  // In-flight counter register
  always_ff @(posedge clk) begin
    if (reset) inflight_q <= '0;
    else       inflight_q <= inflight_d;
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i ({dl_idx_q[CORDIC_LAT-1], cxo, cyo}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_c;
  assign pt_idx    = pt_idx_q;
  assign core_rst  = reset;
  assign cx        = cx_q;
  assign cy        = cy_q;
  assign ca        = ca_q;
  assign out_valid = !fifo_empty;
  assign out_idx   = fifo_rdata[FW-1 -: IDX_W];
  assign out_x     = fifo_rdata[2*OUT_W-1 -: OUT_W];
  assign out_y     = fifo_rdata[OUT_W-1:0];

endmodule

// File: tb/tb_cordic_rotate_sequencer.sv
// Scoreboard bench for cordic_rotate_sequencer with an ideal CORDIC model.
module tb_cordic_rotate_sequencer;

  localparam int NPTS  = 16;
  localparam int IDX_W = 4;
  localparam int LAT   = 14;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [12:0] theta = '0;
  logic        busy, done;
  logic [3:0]  pt_idx;
  logic [5:0]  pt_x, pt_y;
  logic        core_rst;
  logic [11:0] cx, cy;
  logic [12:0] ca;
  logic [9:0]  cxo, cyo;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_idx;
  logic [9:0]  out_x, out_y;

  cordic_rotate_sequencer #(
    .NPTS       (NPTS),
    .IDX_W      (IDX_W),
    .CORDIC_LAT (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .theta     (theta),
    .busy      (busy),
    .done      (done),
    .pt_idx    (pt_idx),
    .pt_x      (pt_x),
    .pt_y      (pt_y),
    .core_rst  (core_rst),
    .cx        (cx),
    .cy        (cy),
    .ca        (ca),
    .cxo       (cxo),
    .cyo       (cyo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_x     (out_x),
    .out_y     (out_y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Point ROM: data valid one cycle after address
  logic [5:0] rom_x [NPTS];
  logic [5:0] rom_y [NPTS];
  always @(posedge clk) begin
    pt_x <= rom_x[pt_idx];
    pt_y <= rom_y[pt_idx];
  end

  // Ideal CORDIC: exact rotation, rounded to Q2.8, LAT cycles of delay
  function automatic logic [9:0] rnd10(input real v);
    int i;
    if (v >= 0.0) i = $rtoi(v + 0.5);
    else          i = -$rtoi(-v + 0.5);
    return 10'(i);
  endfunction

  function automatic logic [9:0] rot_q28(input logic [11:0] xi, input logic [11:0] yi,
                                         input logic [12:0] ai, input bit want_y);
    real x, y, a, r;
    x = $itor($signed(xi)) / 1024.0;
    y = $itor($signed(yi)) / 1024.0;
    a = $itor($signed(ai)) / 1024.0;
    if (want_y) r = x * $sin(a) + y * $cos(a);
    else        r = x * $cos(a) - y * $sin(a);
    return rnd10(r * 256.0);
  endfunction

  logic [9:0] px_pipe [LAT];
  logic [9:0] py_pipe [LAT];
  always @(posedge clk) begin
    if (core_rst) begin
      for (int i = 0; i < LAT; i++) begin
        px_pipe[i] <= '0;
        py_pipe[i] <= '0;
      end
    end else begin
      px_pipe[0] <= rot_q28(cx, cy, ca, 1'b0);
      py_pipe[0] <= rot_q28(cx, cy, ca, 1'b1);
      for (int i = 1; i < LAT; i++) begin
        px_pipe[i] <= px_pipe[i-1];
        py_pipe[i] <= py_pipe[i-1];
      end
    end
  end
  assign cxo = px_pipe[LAT-1];
  assign cyo = py_pipe[LAT-1];

  // Scoreboard state
  typedef struct {
    int idx;
    int x;
    int y;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc = 0;

  function automatic void chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic void chk_tol(input string name, input int act, input int expv, input int tol);
    checks++;
    if ((act > expv + tol) || (act < expv - tol)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d +/-%0d (cycle %0d)", name, act, expv, tol, cyc);
    end
  endfunction

  // Monitor: compare every accepted FIFO head and every done pulse
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got idx %0d expected no output (cycle %0d)", out_idx, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("out_idx", int'(out_idx), e.idx);
        chk_tol("out_x", $signed(out_x), e.x, 1);
        chk_tol("out_y", $signed(out_y), e.y, 1);
        if (out_idx == 4'd0) first_pop_cyc = cyc;
        if (out_idx == 4'(NPTS - 1)) last_pop_cyc = cyc;
      end
    end
    if (!reset && done) begin
      done_cnt++;
      chk("done_after_last_pop", cyc, last_pop_cyc + 1);
      chk("done_fifo_empty", int'(out_valid), 0);
    end
  end

  // out_ready driver: 0 = held low, 1 = held high, 2 = random 50%
  int rdy_mode = 1;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rot: 0 = 0, 1 = +pi/2, 2 = pi, 3 = -pi/2 (hand-derived quarter-turn results)
  task automatic push_batch(input int rot);
    exp_t e;
    int px, py;
    for (int i = 0; i < NPTS; i++) begin
      px = int'(rom_x[i]);
      py = int'(rom_y[i]);
      e.idx = i;
      case (rot)
        0:       begin e.x =  4 * px; e.y =  4 * py; end
        1:       begin e.x = -4 * py; e.y =  4 * px; end
        2:       begin e.x = -4 * px; e.y = -4 * py; end
        default: begin e.x =  4 * py; e.y = -4 * px; end
      endcase
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while ((done_cnt == d0) && (n < budget)) begin
      tick();
      n++;
    end
    chk("done_seen", done_cnt - d0, 1);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("busy_clear", int'(busy), 0);
  endtask

  function automatic logic [12:0] theta_of(input int rot);
    case (rot)
      0:       return 13'h0000;
      1:       return 13'h0648;
      2:       return 13'h0C91;
      default: return 13'h19B8;
    endcase
  endfunction

  task automatic run_batch(input int rot, input bit meas);
    int s0;
    int n;
    push_batch(rot);
    theta = theta_of(rot);
    start = 1'b1;
    tick();
    start = 1'b0;
    s0 = cyc;
    if (meas) begin
      tick();
      tick();
      chk("first_cx_at_2", int'(cx), int'(rom_x[0]) * 16);
      chk("first_cy_at_2", int'(cy), int'(rom_y[0]) * 16);
      n = 0;
      while (!out_valid && (n < 40)) begin
        tick();
        n++;
      end
      chk("first_out_latency", cyc - s0, 2 + LAT + 1);
    end
    wait_done(600);
  endtask

  initial begin
    int d0;
    rom_x[0] = 6'd22;
    rom_y[0] = 6'd10;
    for (int i = 1; i < NPTS; i++) begin
      rom_x[i] = 6'(i * 4 + 3);
      rom_y[i] = 6'(63 - i * 3);
    end

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_pt_idx", int'(pt_idx), 0);
    chk("rst_cx", int'(cx), 0);
    chk("rst_cy", int'(cy), 0);
    chk("rst_ca", int'(ca), 0);
    reset = 1'b0;
    tick();

    // Quarter-turn: vertex 0 (22,10) -> (-40, 88); latency and done timing
    rdy_mode = 1;
    run_batch(1, 1'b1);

    // theta = 0, back-to-back burst of 16
    run_batch(0, 1'b1);
    chk("burst_length", last_pop_cyc - first_pop_cyc, NPTS - 1);

    // Consumer stalled for 100 cycles: FIFO fills, no loss, burst on release
    rdy_mode = 0;
    repeat (2) tick();
    push_batch(2);
    theta = theta_of(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    chk("stall_busy", int'(busy), 1);
    chk("stall_out_valid", int'(out_valid), 1);
    chk("stall_head_idx", int'(out_idx), 0);
    chk("stall_queue_full", exp_q.size(), NPTS);
    rdy_mode = 1;
    wait_done(200);
    chk("release_burst", last_pop_cyc - first_pop_cyc, NPTS - 1);

    // Second start mid-batch with a different angle is ignored
    push_batch(1);
    theta = 13'h0648;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    theta = 13'h0C91;
    start = 1'b1;
    tick();
    start = 1'b0;
    theta = '0;
    chk("ca_held", int'(ca), 'h648);
    chk("busy_held", int'(busy), 1);
    wait_done(600);

    // Reset at cycle 8 of a batch
    theta = 13'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_done", int'(done), 0);
    reset = 1'b0;
    d0 = done_cnt;
    repeat (30) tick();
    chk("midrst_no_done", done_cnt, d0);
    chk("midrst_idle_out", int'(out_valid), 0);
    run_batch(3, 1'b0);

    // Random back-pressure over 50 batches
    rdy_mode = 2;
    d0 = done_cnt;
    for (int b = 0; b < 50; b++) begin
      run_batch(b % 4, 1'b0);
    end
    chk("batch_done_count", done_cnt - d0, 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
